// File: rtl/i2c_master_ctrl.sv
// Single-master I2C bus sequencer: START, address + R/W, ACK slots, data bytes and STOP,
// built on a quarter-bit phase counter of PHASE system clocks per quarter.
module i2c_master_ctrl #(
    parameter int unsigned PHASE = 2
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic [7:0] wr_data,
    output logic       wr_data_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic       scl,
    output logic       sda_out,
    output logic       sda_en,
    input  logic       sda_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(PHASE - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] qtr_q, qtr_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] len_q, len_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       nack_err_q, nack_err_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       wr_req_q, wr_req_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       scl_q, scl_d;
    logic       sda_out_q, sda_out_d;
    logic       sda_en_q, sda_en_d;
    logic       tick_s, bit_end_s, sample_s, scl_pat_s;

    // STOP stretches to five quarters so SDA can rise after a full high SCL half-bit.
    assign tick_s    = (cnt_q == PH_LAST);
    assign bit_end_s = tick_s && (qtr_q == ((state_q == S_STOP) ? 3'd4 : 3'd3));
    // Bus pins lag the state by one register, so the mid-high bus cycle is state q2, cycle 0.
    assign sample_s  = (qtr_q == 3'd2) && (cnt_q == 8'd0);
    assign scl_pat_s = (qtr_q == 3'd1) || (qtr_q == 3'd2);

    // Next-state, phase counter and handshake computation.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        len_d      = len_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        nack_err_d = nack_err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_req_d   = 1'b0;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = 8'd0;
            qtr_d = 3'd0;
        end else if (bit_end_s) begin
            cnt_d = 8'd0;
            qtr_d = 3'd0;
        end else if (tick_s) begin
            cnt_d = 8'd0;
            qtr_d = qtr_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 8'd1;
            qtr_d = qtr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d    = S_START;
                    shift_d    = {cmd_addr, cmd_rw};
                    rw_d       = cmd_rw;
                    len_d      = cmd_len;
                    nack_err_d = 1'b0;
                    bit_d      = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s && (bit_q == 3'd1)) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd7;
                end else if (bit_end_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    bit_d = bit_q;
                end
            end
            S_ADDR, S_WDATA: begin
                // wr_data_req is only ever high in the first cycle of WDATA bit 7.
                if (wr_req_q) begin
                    shift_d = wr_data;
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s && (bit_q == 3'd0)) begin
                    state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                end else if (bit_end_s) begin
                    bit_d = bit_q - 3'd1;
                end else begin
                    bit_d = bit_q;
                end
            end
            S_AACK, S_WACK: begin
                if (sample_s) begin
                    ack_d = sda_in;
                end else begin
                    ack_d = ack_q;
                end
                if (bit_end_s && ack_q) begin
                    nack_err_d = 1'b1;
                    state_d    = S_STOP;
                end else if (bit_end_s) begin
                    if (state_q == S_WACK) begin
                        len_d = len_q - 8'd1;
                    end else begin
                        len_d = len_q;
                    end
                    if ((state_q == S_AACK && len_q == 8'd0) || (state_q == S_WACK && len_q == 8'd1)) begin
                        state_d = S_STOP;
                    end else if (rw_q) begin
                        state_d = S_RDATA;
                        bit_d   = 3'd7;
                    end else begin
                        state_d  = S_WDATA;
                        bit_d    = 3'd7;
                        wr_req_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_RDATA: begin
                if (sample_s && (bit_q == 3'd0)) begin
                    shift_d    = {shift_q[6:0], sda_in};
                    rd_data_d  = {shift_q[6:0], sda_in};
                    rd_valid_d = 1'b1;
                end else if (sample_s) begin
                    shift_d = {shift_q[6:0], sda_in};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s && (bit_q == 3'd0)) begin
                    state_d = S_RACK;
                end else if (bit_end_s) begin
                    bit_d = bit_q - 3'd1;
                end else begin
                    bit_d = bit_q;
                end
            end
            S_RACK: begin
                if (bit_end_s) begin
                    len_d   = len_q - 8'd1;
                    state_d = (len_q == 8'd1) ? S_STOP : S_RDATA;
                    bit_d   = 3'd7;
                end else begin
                    len_d = len_q;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    // Bus pin values for the current state and quarter.
    always_comb begin
        scl_d     = 1'b1;
        sda_out_d = 1'b1;
        sda_en_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                scl_d = 1'b1;
            end
            S_START: begin
                sda_en_d  = 1'b1;
                scl_d     = (bit_q == 3'd0);
                sda_out_d = (bit_q == 3'd0) && (qtr_q < 3'd2);
            end
            S_ADDR: begin
                sda_en_d  = 1'b1;
                scl_d     = scl_pat_s;
                sda_out_d = shift_q[bit_q];
            end
            S_WDATA: begin
                sda_en_d  = 1'b1;
                scl_d     = scl_pat_s;
                sda_out_d = wr_req_q ? wr_data[7] : shift_q[bit_q];
            end
            S_AACK, S_WACK, S_RDATA: begin
                scl_d = scl_pat_s;
            end
            S_RACK: begin
                sda_en_d  = 1'b1;
                scl_d     = scl_pat_s;
                sda_out_d = (len_q == 8'd1);
            end
            S_STOP: begin
                sda_en_d  = 1'b1;
                scl_d     = (qtr_q != 3'd0);
                sda_out_d = (qtr_q >= 3'd3);
            end
            default: begin
                scl_d = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            qtr_q       <= 3'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            len_q       <= 8'd0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            nack_err_q  <= 1'b0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
            wr_req_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            scl_q       <= 1'b1;
            sda_out_q   <= 1'b1;
            sda_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            nack_err_q  <= nack_err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_req_q    <= wr_req_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            scl_q       <= scl_d;
            sda_out_q   <= sda_out_d;
            sda_en_q    <= sda_en_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wr_data_req = wr_req_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign nack_err    = nack_err_q;
    assign scl         = scl_q;
    assign sda_out     = sda_out_q;
    assign sda_en      = sda_en_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a behavioural I2C slave/bus decoder plus a byte-level
// transaction model; random and directed transactions are compared against the model.
module tb_i2c_master_ctrl;

    localparam int P = 2;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_len, wr_data, rd_data;
    logic       wr_data_req, rd_valid, busy, done, nack_err;
    logic       scl, sda_out, sda_en, sda_line, slave_sda;

    assign sda_line = (sda_en ? sda_out : 1'b1) & slave_sda;

    i2c_master_ctrl #(.PHASE(P)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
        .wr_data_req(wr_data_req), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .done(done), .nack_err(nack_err), .scl(scl), .sda_out(sda_out), .sda_en(sda_en),
        .sda_in(sda_line)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration and byte data, written by the stimulus process only.
    logic [7:0] wr_bytes [256];
    logic [7:0] rd_bytes [256];
    bit         cfg_addr_ack = 1'b1;
    int         cfg_nack_idx = -1;
    bit         mon_clr = 1'b0;

    // Bus observations, written by the monitor processes only.
    logic [7:0] got_bytes[$];
    logic       got_acks[$];
    logic [7:0] got_rd[$];
    int n_start, n_stop, t_start, t_stop, n_wreq, n_done, n_accept, cyc, bitn;
    logic [7:0] cur;
    logic ackbit, prev_scl, prev_sda;
    bit rd_active;

    function automatic logic slave_next(input int n);
        int b;
        b = got_bytes.size();
        if (b == 0) return (n == 8) ? !cfg_addr_ack : 1'b1;
        else if (!got_bytes[0][0]) return (n == 8) ? ((b - 1) == cfg_nack_idx) : 1'b1;
        else if (rd_active && n < 8) return rd_bytes[b - 1][7 - n];
        else return 1'b1;
    endfunction

    // I2C slave + bus decoder + write-data supplier, evaluated mid-cycle.
    initial begin
        slave_sda = 1'b1; wr_data = 8'h00; prev_scl = 1'b1; prev_sda = 1'b1;
        cyc = 0; bitn = 0; cur = 8'h00; ackbit = 1'b1; rd_active = 1'b0;
        n_start = 0; n_stop = 0; t_start = 0; t_stop = 0; n_wreq = 0; n_done = 0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (mon_clr) begin
                got_bytes.delete(); got_acks.delete(); got_rd.delete();
                n_start = 0; n_stop = 0; t_start = 0; t_stop = 0; n_wreq = 0; n_done = 0;
                bitn = 0; rd_active = 1'b0; slave_sda = 1'b1;
            end
            if (wr_data_req) begin
                wr_data = wr_bytes[n_wreq % 256];
                n_wreq++;
            end
            if (rd_valid) got_rd.push_back(rd_data);
            if (done) n_done++;
            if (scl && prev_scl && prev_sda && !sda_line) begin
                n_start++; t_start = cyc; bitn = 0; cur = 8'h00;
            end else if (scl && prev_scl && !prev_sda && sda_line) begin
                n_stop++; t_stop = cyc; bitn = 0; rd_active = 1'b0; slave_sda = 1'b1;
            end else if (scl && !prev_scl) begin
                if (bitn < 8) cur = {cur[6:0], sda_line};
                else ackbit = sda_line;
                bitn++;
            end else if (!scl && prev_scl) begin
                if (bitn == 9) begin
                    got_bytes.push_back(cur);
                    got_acks.push_back(ackbit);
                    bitn = 0;
                    if (got_bytes.size() == 1) rd_active = got_bytes[0][0] && !ackbit;
                    else if (got_bytes[0][0]) rd_active = !ackbit;
                end
                slave_sda = slave_next(bitn);
            end
            prev_scl = scl;
            prev_sda = sda_line;
        end
    end

    // Command-accept counter on the active edge.
    initial begin
        n_accept = 0;
        forever begin
            @(posedge sys_clk);
            if (mon_clr) n_accept = 0;
            else if (rst_n && cmd_valid && cmd_ready) n_accept++;
        end
    end

    task automatic mon_clear();
        @(negedge sys_clk);
        mon_clr = 1'b1;
        repeat (2) @(negedge sys_clk);
        mon_clr = 1'b0;
    endtask

    task automatic run_txn(input logic rw, input logic [6:0] addr, input logic [7:0] len,
                           input bit addr_ack, input int nack_idx, input bit hold);
        logic [7:0] exp_bytes[$];
        logic       exp_acks[$];
        logic [7:0] exp_rd[$];
        logic       exp_nack;
        int         exp_wreq, lim, nb;
        bit         got;
        cfg_addr_ack = addr_ack;
        cfg_nack_idx = nack_idx;
        mon_clear();
        // Byte-level expectation from the protocol rules.
        exp_bytes.push_back({addr, rw});
        exp_acks.push_back(!addr_ack);
        exp_nack = !addr_ack;
        exp_wreq = 0;
        if (addr_ack) begin
            for (int i = 0; i < int'(len); i++) begin
                if (!rw) begin
                    exp_bytes.push_back(wr_bytes[i]);
                    exp_acks.push_back(i == nack_idx);
                    exp_wreq++;
                    if (i == nack_idx) begin
                        exp_nack = 1'b1;
                        break;
                    end
                end else begin
                    exp_bytes.push_back(rd_bytes[i]);
                    exp_acks.push_back(i == int'(len) - 1);
                    exp_rd.push_back(rd_bytes[i]);
                end
            end
        end
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_len = len;
        @(negedge sys_clk);
        check_val("busy_after_accept", busy, 1);
        check_val("ready_after_accept", cmd_ready, 0);
        check_val("nack_clr_on_accept", nack_err, 0);
        if (hold) begin
            cmd_addr = addr ^ 7'h2A; cmd_rw = ~rw; cmd_len = len + 8'd3;
        end else begin
            cmd_valid = 1'b0; cmd_addr = 7'($urandom); cmd_rw = 1'($urandom); cmd_len = 8'($urandom);
        end
        lim = 4 * P * 9 * (int'(len) + 3) + 200;
        got = 1'b0;
        for (int c = 0; c < lim; c++) begin
            @(negedge sys_clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check_val("done_seen", got, 1);
        check_val("nack_err", nack_err, exp_nack);
        check_val("busy_at_done", busy, 0);
        repeat (4) @(negedge sys_clk);
        check_val("n_start", n_start, 1);
        check_val("n_stop", n_stop, 1);
        check_val("n_accept", n_accept, 1);
        check_val("n_done", n_done, 1);
        check_val("n_wr_req", n_wreq, exp_wreq);
        check_val("n_bytes", got_bytes.size(), exp_bytes.size());
        nb = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        for (int i = 0; i < nb; i++) begin
            check_val($sformatf("byte%0d", i), got_bytes[i], exp_bytes[i]);
            check_val($sformatf("ack%0d", i), got_acks[i], exp_acks[i]);
        end
        check_val("n_rd_valid", got_rd.size(), exp_rd.size());
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            check_val($sformatf("rd_data%0d", i), got_rd[i], exp_rd[i]);
        check_val("start_to_stop_clks", t_stop - t_start, 6 * P + 9 * exp_bytes.size() * 4 * P + 3 * P);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'h00; cmd_len = 8'h00;
        repeat (3) @(negedge sys_clk);
        check_val("rst_scl", scl, 1);
        check_val("rst_sda_out", sda_out, 1);
        check_val("rst_sda_en", sda_en, 0);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_wr_req", wr_data_req, 0);
        check_val("rst_nack_err", nack_err, 0);
        check_val("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        wr_bytes[0] = 8'hC1; wr_bytes[1] = 8'hC2;
        run_txn(1'b0, 7'h7A, 8'd2, 1'b1, -1, 1'b0);
        rd_bytes[0] = 8'h91; rd_bytes[1] = 8'h92;
        run_txn(1'b1, 7'h7A, 8'd2, 1'b1, -1, 1'b0);
        run_txn(1'b0, 7'h7A, 8'd2, 1'b0, -1, 1'b0);
        run_txn(1'b0, 7'h7A, 8'd0, 1'b1, -1, 1'b0);
        wr_bytes[0] = 8'h5A; wr_bytes[1] = 8'hA5; wr_bytes[2] = 8'h3C;
        run_txn(1'b0, 7'h13, 8'd3, 1'b1, 1, 1'b0);

        // Reset in the middle of WDATA bit 3.
        cfg_addr_ack = 1'b1; cfg_nack_idx = -1;
        mon_clear();
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h21; cmd_len = 8'd3;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200 * P; c++) begin
            @(negedge sys_clk);
            if (wr_data_req) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("wr_req_before_reset", ok, 1);
        repeat (16 * P + 2) @(negedge sys_clk);
        check_val("busy_before_reset", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_scl", scl, 1);
        check_val("mid_rst_sda_en", sda_en, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        wr_bytes[0] = 8'h66; wr_bytes[1] = 8'h99;
        run_txn(1'b0, 7'h21, 8'd2, 1'b1, -1, 1'b0);

        // cmd_valid held with a changing address throughout the transaction.
        rd_bytes[0] = 8'hE7;
        run_txn(1'b1, 7'h35, 8'd1, 1'b1, -1, 1'b1);

        for (int t = 0; t < 8; t++) begin
            logic       rw;
            logic [7:0] len;
            bit         aa;
            int         ni;
            rw  = 1'($urandom);
            len = 8'($urandom_range(0, 4));
            aa  = ($urandom % 5) != 0;
            ni  = (!rw && ($urandom % 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            for (int i = 0; i < 8; i++) begin
                wr_bytes[i] = 8'($urandom);
                rd_bytes[i] = 8'($urandom);
            end
            run_txn(rw, 7'($urandom), len, aa, ni, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
